axis_seq_divider: RTL

AXIS_SEQ_DIVIDER -- requirements
Module: axis_seq_divider

---
 rtl/seq_div_pkg.sv | 23 ++
 rtl/axis_seq_divider_if.sv | 57 +++++
 rtl/seq_div_core.sv | 79 +++++++
 rtl/axis_seq_divider.sv | 122 ++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential AXI-Stream divider.
//   - default width constants for dividend, divisor/remainder and quotient
//   - result field offsets inside m_axis_dout_tdata
//   - controller state enumeration (IDLE / CALC / OUT)
// Build option: SEQ_DIV_BACKPRESSURE_EN (see axis_seq_divider.sv).
package seq_div_pkg;

  localparam int unsigned DEF_DIVIDEND_W = 64;
  localparam int unsigned DEF_DIVISOR_W  = 32;
  localparam int unsigned DEF_QUOT_W     = 56;

  // dout = {quotient, remainder}; the remainder sits at bit 0 and the
  // quotient starts directly above it (QUOT_LSB == DIVISOR_W in general).
  localparam int unsigned REM_LSB  = 0;
  localparam int unsigned QUOT_LSB = DEF_DIVISOR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/axis_seq_divider_if.sv
// Stream bundle for axis_seq_divider.
//   s_axis_divisor_*  : divisor input channel (tvalid/tready/tdata)
//   s_axis_dividend_* : dividend input channel (tvalid/tready/tdata)
//   m_axis_dout_*     : result channel {quotient, remainder}
//   m_axis_dout_tready only exists when SEQ_DIV_BACKPRESSURE_EN is defined.
// Modports: master = stimulus/source side, slave = divider side.
interface axis_seq_divider_if
  import seq_div_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int unsigned DIVISOR_W  = DEF_DIVISOR_W,
  parameter int unsigned QUOT_W     = DEF_QUOT_W
) ();

  logic                        s_axis_divisor_tvalid;
  logic                        s_axis_divisor_tready;
  logic [DIVISOR_W-1:0]        s_axis_divisor_tdata;
  logic                        s_axis_dividend_tvalid;
  logic                        s_axis_dividend_tready;
  logic [DIVIDEND_W-1:0]       s_axis_dividend_tdata;
  logic                        m_axis_dout_tvalid;
  logic [QUOT_W+DIVISOR_W-1:0] m_axis_dout_tdata;
`ifdef SEQ_DIV_BACKPRESSURE_EN
  logic                        m_axis_dout_tready;

  modport master (
    output s_axis_divisor_tvalid, s_axis_divisor_tdata,
    output s_axis_dividend_tvalid, s_axis_dividend_tdata,
    output m_axis_dout_tready,
    input  s_axis_divisor_tready, s_axis_dividend_tready,
    input  m_axis_dout_tvalid, m_axis_dout_tdata
  );

  modport slave (
    input  s_axis_divisor_tvalid, s_axis_divisor_tdata,
    input  s_axis_dividend_tvalid, s_axis_dividend_tdata,
    input  m_axis_dout_tready,
    output s_axis_divisor_tready, s_axis_dividend_tready,
    output m_axis_dout_tvalid, m_axis_dout_tdata
  );
`else
  modport master (
    output s_axis_divisor_tvalid, s_axis_divisor_tdata,
    output s_axis_dividend_tvalid, s_axis_dividend_tdata,
    input  s_axis_divisor_tready, s_axis_dividend_tready,
    input  m_axis_dout_tvalid, m_axis_dout_tdata
  );

  modport slave (
    input  s_axis_divisor_tvalid, s_axis_divisor_tdata,
    input  s_axis_dividend_tvalid, s_axis_dividend_tdata,
    output s_axis_divisor_tready, s_axis_dividend_tready,
    output m_axis_dout_tvalid, m_axis_dout_tdata
  );
`endif

endinterface

// File: rtl/seq_div_core.sv
// Radix-2 restoring divider datapath: one dividend bit per cycle, MSB first,
// DIVIDEND_W iterations after a start pulse.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : load dividend/divisor and begin (1-cycle pulse)
//   dividend   : unsigned dividend
//   divisor    : unsigned divisor (0 yields all-ones quotient, rem = dividend LSBs)
//   busy       : iterations in progress
//   done       : 1-cycle pulse after the final iteration; results valid from then
//   quotient   : low QUOT_W quotient bits
//   remainder  : exact remainder
module seq_div_core #(
  parameter int unsigned DIVIDEND_W = 64,
  parameter int unsigned DIVISOR_W  = 32,
  parameter int unsigned QUOT_W     = 56
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [QUOT_W-1:0]     quotient,
  output logic [DIVISOR_W-1:0]  remainder
);

  localparam int unsigned CNT_W = $clog2(DIVIDEND_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDEND_W - 1);

  // Dividend bits shift out of the MSB while quotient bits shift into the LSB.
  logic [DIVIDEND_W-1:0] shreg;
  logic [DIVISOR_W-1:0]  prem;
  logic [DIVISOR_W-1:0]  dsr;
  logic [CNT_W-1:0]      cnt;

  logic [DIVISOR_W:0]    trial;
  logic                  fits;
  logic [DIVISOR_W-1:0]  diff;

  // The trial value is the DIVISOR_W+1-bit partial remainder. When it fits,
  // the difference is below the divisor, so DIVISOR_W bits hold it exactly.
  always_comb begin
    trial = {prem, shreg[DIVIDEND_W-1]};
    fits  = (trial >= {1'b0, dsr});
    diff  = trial[DIVISOR_W-1:0] - dsr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      prem  <= '0;
      dsr   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        shreg <= dividend;
        dsr   <= divisor;
        prem  <= '0;
        cnt   <= '0;
        busy  <= 1'b1;
      end else if (busy) begin
        shreg <= {shreg[DIVIDEND_W-2:0], fits};
        prem  <= fits ? diff : trial[DIVISOR_W-1:0];
        cnt   <= cnt + 1'b1;
        if (cnt == LAST) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient  = shreg[QUOT_W-1:0];
  assign remainder = prem;

endmodule

// File: rtl/axis_seq_divider.sv
// Sequential unsigned divider with AXI-Stream style input and result channels.
// Each input channel has a one-entry slot; once both are full the FSM runs
// seq_div_core for DIVIDEND_W cycles and presents {quotient, remainder}.
//   clk  : clock (rising edge)
//   rst  : asynchronous active-high reset
//   bus  : axis_seq_divider_if.slave (divisor, dividend and dout channels)
// Build option SEQ_DIV_BACKPRESSURE_EN: adds m_axis_dout_tready and holds
// the result until accepted; otherwise the result is a 1-cycle tvalid pulse.
module axis_seq_divider
  import seq_div_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int unsigned DIVISOR_W  = DEF_DIVISOR_W,
  parameter int unsigned QUOT_W     = DEF_QUOT_W
) (
  input logic               clk,
  input logic               rst,
  axis_seq_divider_if.slave bus
);

  localparam int unsigned QUOT_OFS = REM_LSB + DIVISOR_W;

  state_t                      state;
  logic                        div_rdy;
  logic                        dvd_rdy;
  logic [DIVISOR_W-1:0]        div_slot;
  logic [DIVIDEND_W-1:0]       dvd_slot;
  logic                        dout_valid;
  logic [QUOT_W+DIVISOR_W-1:0] dout_data;

  logic                        div_hs;
  logic                        dvd_hs;
  logic                        start;
  logic                        out_ack;
  logic [DIVISOR_W-1:0]        core_divisor;
  logic [DIVIDEND_W-1:0]       core_dividend;
  logic                        core_busy;
  logic                        core_done;
  logic [QUOT_W-1:0]           core_quot;
  logic [DIVISOR_W-1:0]        core_rem;

  assign div_hs = bus.s_axis_divisor_tvalid  & div_rdy;
  assign dvd_hs = bus.s_axis_dividend_tvalid & dvd_rdy;

  // Start on the edge that fills the last slot; the core takes the operand
  // straight from the bus when it is being captured on that same edge.
  assign start         = (state == IDLE) & ~core_busy
                       & (~div_rdy | div_hs) & (~dvd_rdy | dvd_hs);
  assign core_divisor  = div_hs ? bus.s_axis_divisor_tdata  : div_slot;
  assign core_dividend = dvd_hs ? bus.s_axis_dividend_tdata : dvd_slot;

`ifdef SEQ_DIV_BACKPRESSURE_EN
  assign out_ack = bus.m_axis_dout_tready;
`else
  assign out_ack = 1'b1;
`endif

  seq_div_core #(
    .DIVIDEND_W (DIVIDEND_W),
    .DIVISOR_W  (DIVISOR_W),
    .QUOT_W     (QUOT_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (core_dividend),
    .divisor   (core_divisor),
    .busy      (core_busy),
    .done      (core_done),
    .quotient  (core_quot),
    .remainder (core_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      div_rdy    <= 1'b1;
      dvd_rdy    <= 1'b1;
      div_slot   <= '0;
      dvd_slot   <= '0;
      dout_valid <= 1'b0;
      dout_data  <= '0;
    end else begin
      if (div_hs) begin
        div_slot <= bus.s_axis_divisor_tdata;
        div_rdy  <= 1'b0;
      end
      if (dvd_hs) begin
        dvd_slot <= bus.s_axis_dividend_tdata;
        dvd_rdy  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start) state <= CALC;
        end
        CALC: begin
          if (core_done) begin
            state                          <= OUT;
            dout_valid                     <= 1'b1;
            dout_data[REM_LSB +: DIVISOR_W] <= core_rem;
            dout_data[QUOT_OFS +: QUOT_W]   <= core_quot;
          end
        end
        OUT: begin
          if (out_ack) begin
            state      <= IDLE;
            dout_valid <= 1'b0;
            div_rdy    <= 1'b1;
            dvd_rdy    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s_axis_divisor_tready  = div_rdy;
  assign bus.s_axis_dividend_tready = dvd_rdy;
  assign bus.m_axis_dout_tvalid     = dout_valid;
  assign bus.m_axis_dout_tdata      = dout_data;

endmodule
